// File: rtl/reg_file_2r1w.sv
// Integer register file (x0..x31) for the single-cycle RISC-V datapath.
// Two combinational read ports, one write port, a debug read port and a saturating write counter.
module reg_file_2r1w #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [XLEN-1:0]   rd_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [XLEN-1:0]   dbg_data,
    output logic [15:0]       wr_count
);

    localparam int DEPTH = 1 << ADDR_W;

    // x0 has no storage; only entries 1..DEPTH-1 exist as flops.
    logic [XLEN-1:0] store [1:DEPTH-1];

    logic wr_en;
    logic byp1;
    logic byp2;
    logic [XLEN-1:0] stored1;
    logic [XLEN-1:0] stored2;
    logic [XLEN-1:0] stored_dbg;

    assign wr_en = reg_write && (rd_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr_en && (rd_addr == ADDR_W'(i))) begin
                    store[i] <= rd_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
        end else if (wr_en && (wr_count != 16'hFFFF)) begin
            wr_count <= wr_count + 16'd1;
        end
    end

    // Address 0 falls through every compare and reads as zero.
    always_comb begin
        stored1    = '0;
        stored2    = '0;
        stored_dbg = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (rs1_addr == ADDR_W'(i)) stored1    = store[i];
            if (rs2_addr == ADDR_W'(i)) stored2    = store[i];
            if (dbg_addr == ADDR_W'(i)) stored_dbg = store[i];
        end
    end

    // Forwarding is suppressed in reset so every port reads zero while rst_n is low.
    assign byp1 = (BYPASS != 0) && rst_n && wr_en && (rd_addr == rs1_addr);
    assign byp2 = (BYPASS != 0) && rst_n && wr_en && (rd_addr == rs2_addr);

    assign rs1_data = byp1 ? rd_data : stored1;
    assign rs2_data = byp2 ? rd_data : stored2;
    assign dbg_data = stored_dbg;

endmodule
